// File: rtl/wdt_pkg.sv
// Shared types and register offsets for the watchdog timeout generator.
package wdt_pkg;

  localparam int unsigned WDT_ADDR_W = 12;
  localparam int unsigned WDT_DATA_W = 32;

  typedef enum logic [1:0] {
    WDT_IDLE    = 2'd0,
    WDT_COUNT   = 2'd1,
    WDT_TIMEOUT = 2'd2
  } wdt_state_e;

  localparam logic [WDT_ADDR_W-1:0] WDT_ADDR_WDEN   = 12'h100;
  localparam logic [WDT_ADDR_W-1:0] WDT_ADDR_WDLIVE = 12'h200;
  localparam logic [WDT_ADDR_W-1:0] WDT_ADDR_WTOCNT = 12'h300;
  localparam logic [WDT_ADDR_W-1:0] WDT_ADDR_STATUS = 12'h400;
  localparam logic [WDT_ADDR_W-1:0] WDT_ADDR_COUNT  = 12'h404;

endpackage

// File: rtl/wdt_prescaler.sv
// Modulo-PRESCALE cycle divider feeding the watchdog tick counter.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   en   - advance the divider this cycle
//   clr  - restart the divider at 0 (wins over en)
//   tick - high on the last cycle of each PRESCALE period while enabled
module wdt_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // Wraps to 0 on the tick cycle; frozen when not enabled.
  always_comb begin
    tick  = en & (pre_q == LAST);
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/wdt_timeout_gen.sv
// Watchdog timer: register-programmed limit, software kick, level timeout output.
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   reg_req   - register access request (one access per request)
//   reg_we    - 1 = write, 0 = read
//   reg_addr  - register offset
//   reg_wdata - write data
//   reg_ack   - one-cycle acknowledge
//   reg_rdata - read data, valid while reg_ack=1
//   timeout   - level watchdog expiry
module wdt_timeout_gen
  import wdt_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_req,
  input  logic                  reg_we,
  input  logic [WDT_ADDR_W-1:0] reg_addr,
  input  logic [WDT_DATA_W-1:0] reg_wdata,
  output logic                  reg_ack,
  output logic [WDT_DATA_W-1:0] reg_rdata,
  output logic                  timeout
);

  wdt_state_e            state_q, state_d;
  logic                  wden_q, wden_d;
  logic [CNT_W-1:0]      wtocnt_q, wtocnt_d;
  logic [CNT_W-1:0]      limit_q, limit_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [WDT_DATA_W-1:0] rdata_q, rdata_d;
  logic                  timeout_q, timeout_d;

  logic                  acc, wr, rd;
  logic                  wr_wden, wr_kick, wr_wto;
  logic                  pre_en, pre_clr, tick;
  logic [WDT_DATA_W-1:0] rd_val;

  // A request is accepted only when the previous ack has dropped.
  assign acc     = reg_req & ~ack_q;
  assign wr      = acc & reg_we;
  assign rd      = acc & ~reg_we;
  assign wr_wden = wr & (reg_addr == WDT_ADDR_WDEN);
  assign wr_kick = wr & (reg_addr == WDT_ADDR_WDLIVE) & reg_wdata[0];
  assign wr_wto  = wr & (reg_addr == WDT_ADDR_WTOCNT);
  assign pre_en  = (state_q == WDT_COUNT);

  wdt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );

  // Read mux: pre-edge register contents.
  always_comb begin
    rd_val = '0;
    case (reg_addr)
      WDT_ADDR_WDEN:   rd_val = {{(WDT_DATA_W-1){1'b0}}, wden_q};
      WDT_ADDR_WTOCNT: rd_val = WDT_DATA_W'(wtocnt_q);
      WDT_ADDR_STATUS: rd_val = {28'b0, (state_q == WDT_TIMEOUT), state_q, wden_q};
      WDT_ADDR_COUNT:  rd_val = WDT_DATA_W'(cnt_q);
      default:         rd_val = '0;
    endcase
  end

  // Next-state: bus registers, FSM and tick counter.
  always_comb begin
    state_d  = state_q;
    wden_d   = wden_q;
    wtocnt_d = wtocnt_q;
    limit_d  = limit_q;
    cnt_d    = cnt_q;
    pre_clr  = 1'b0;
    ack_d    = acc;
    rdata_d  = rdata_q;

    if (wr_wden) wden_d = reg_wdata[0];
    if (wr_wto)  wtocnt_d = CNT_W'(reg_wdata);
    if (acc)     rdata_d = rd ? rd_val : '0;

    case (state_q)
      WDT_IDLE: begin
        if (wr_wden && reg_wdata[0]) begin
          state_d = WDT_COUNT;
          cnt_d   = '0;
          pre_clr = 1'b1;
          limit_d = wtocnt_q;
        end
      end
      WDT_COUNT: begin
        // Kick beats a coincident terminal tick.
        if (wr_kick) begin
          cnt_d   = '0;
          pre_clr = 1'b1;
          limit_d = wtocnt_q;
        end else if (tick) begin
          if (cnt_q == limit_q) state_d = WDT_TIMEOUT;
          else                  cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      WDT_TIMEOUT: begin
        if (wr_kick) begin
          state_d = WDT_COUNT;
          cnt_d   = '0;
          pre_clr = 1'b1;
          limit_d = wtocnt_q;
        end
      end
      default: state_d = WDT_IDLE;
    endcase

    // Disarm overrides everything, including a terminal tick.
    if (wr_wden && !reg_wdata[0]) begin
      state_d = WDT_IDLE;
      cnt_d   = '0;
      pre_clr = 1'b1;
    end

    timeout_d = (state_d == WDT_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WDT_IDLE;
      wden_q    <= 1'b0;
      wtocnt_q  <= '0;
      limit_q   <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wden_q    <= wden_d;
      wtocnt_q  <= wtocnt_d;
      limit_q   <= limit_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_wdt_timeout_gen.sv
// Self-checking bench for wdt_timeout_gen (PRESCALE=4, CNT_W=32).
module tb_wdt_timeout_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_req;
  logic        reg_we;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mon_hits = 0;
  bit mon_en  = 1'b0;

  wdt_timeout_gen #(.PRESCALE(4), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .reg_req  (reg_req),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_ack  (reg_ack),
    .reg_rdata(reg_rdata),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mon_en && timeout) mon_hits <= mon_hits + 1;

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write; returns the cycle count of the edge where the write took effect.
  task automatic wr(input logic [11:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    e = cyc;
    reg_req = 1'b0; reg_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a; reg_wdata = '0;
    @(posedge clk); #1;
    chk({name, "_ack"}, 32'(reg_ack), 32'd1);
    chk(name, reg_rdata, exp);
    reg_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Waits for timeout to rise and checks the edge distance from start.
  task automatic wait_to(input string name, input int start, input int exp_d);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (timeout) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout never rose, expected after %0d edges", name, exp_d);
    end else begin
      chk(name, 32'(cyc - start), 32'(exp_d));
    end
  endtask

  initial begin
    int e0, ek, ed;
    rst = 1'b1; reg_req = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(reg_ack), 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Register map vectors
    vecs.push_back('{0, 12'h100, 32'h0, 32'h0});
    vecs.push_back('{0, 12'h300, 32'h0, 32'h0});
    vecs.push_back('{0, 12'h400, 32'h0, 32'h0});
    vecs.push_back('{0, 12'h404, 32'h0, 32'h0});
    vecs.push_back('{0, 12'h200, 32'h0, 32'h0});
    vecs.push_back('{1, 12'h300, 32'h5, 32'h0});
    vecs.push_back('{0, 12'h300, 32'h0, 32'h5});
    vecs.push_back('{1, 12'h300, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{0, 12'h300, 32'h0, 32'hFFFF_FFFF});
    vecs.push_back('{1, 12'h200, 32'h1, 32'h0});
    vecs.push_back('{0, 12'h400, 32'h0, 32'h0});
    vecs.push_back('{1, 12'h7FC, 32'hDEAD, 32'h0});
    vecs.push_back('{0, 12'h7FC, 32'h0, 32'h0});
    vecs.push_back('{0, 12'h104, 32'h0, 32'h0});
    vecs.push_back('{1, 12'h100, 32'h0, 32'h0});
    vecs.push_back('{0, 12'h400, 32'h0, 32'h0});
    vecs.push_back('{1, 12'h300, 32'h3, 32'h0});
    vecs.push_back('{0, 12'h300, 32'h0, 32'h3});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata, ed);
      else            rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Arm, no kicks; a redundant WDEN=1 mid-count changes nothing
    wr(12'h100, 32'h1, e0);
    wait_until(e0 + 4);
    wr(12'h100, 32'h1, ed);
    wait_to("expire_16", e0, 16);
    rd("count_at_to", 12'h404, 32'd3);
    rd("status_to", 12'h400, 32'hD);

    // WDLIVE with bit0=0 ignored; kick clears timeout and restarts
    wr(12'h200, 32'h2, ed);
    chk("live0_ignored", 32'(timeout), 32'd1);
    wr(12'h200, 32'h1, ek);
    chk("kick_from_to", 32'(timeout), 32'd0);
    rd("status_kick", 12'h400, 32'h3);
    rd("count_kick", 12'h404, 32'd0);
    wait_to("reexpire_16", ek, 16);

    // Kick every 12 edges for ~200 edges
    mon_hits = 0;
    wr(12'h200, 32'h1, ek);
    mon_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rd($sformatf("kick%0d_cnt0", i), 12'h404, 32'd0);
      wait_until(ek + 9);
      rd($sformatf("kick%0d_cnt2", i), 12'h404, 32'd2);
      wait_until(ek + 11);
      wr(12'h200, 32'h1, ek);
    end
    wait_until(ek + 10);
    mon_en = 1'b0;
    chk("kick_no_timeout", 32'(mon_hits), 32'd0);

    // New WTOCNT does not disturb a running count; kick picks it up
    wr(12'h100, 32'h0, ed);
    wr(12'h100, 32'h1, e0);
    wr(12'h300, 32'h7, ed);
    wait_to("old_limit", e0, 16);
    wr(12'h200, 32'h1, ek);
    wait_to("new_limit", ek, 32);
    wr(12'h300, 32'h3, ed);

    // Kick, then disarm, landing on terminal-tick edges
    wr(12'h100, 32'h0, ed);
    wr(12'h100, 32'h1, e0);
    mon_hits = 0;
    mon_en = 1'b1;
    wait_until(e0 + 15);
    wr(12'h200, 32'h1, ek);
    chk("kick_edge", 32'(ek - e0), 32'd16);
    wait_until(e0 + 31);
    wr(12'h100, 32'h0, ed);
    chk("disarm_edge", 32'(ed - e0), 32'd32);
    wait_until(e0 + 60);
    mon_en = 1'b0;
    chk("terminal_no_timeout", 32'(mon_hits), 32'd0);
    rd("status_disarm", 12'h400, 32'h0);

    // Reset while in TIMEOUT with a request pending
    wr(12'h100, 32'h1, e0);
    wait_to("pre_rst_expire", e0, 16);
    @(negedge clk);
    rst = 1'b1; reg_req = 1'b1; reg_we = 1'b0; reg_addr = 12'h400;
    @(posedge clk); #1;
    chk("rst_to_timeout", 32'(timeout), 32'd0);
    chk("rst_to_ack", 32'(reg_ack), 32'd0);
    chk("rst_to_rdata", reg_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; reg_req = 1'b0;
    rd("rst_wtocnt", 12'h300, 32'd0);
    rd("rst_wden", 12'h100, 32'd0);
    rd("rst_status", 12'h400, 32'd0);
    rd("unmapped_7fc", 12'h7FC, 32'd0);

    // limit=0 expires after a single tick
    wr(12'h100, 32'h1, e0);
    wait_to("limit0_expire", e0, 4);
    rd("limit0_count", 12'h404, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
